// File: rtl/mips_multicycle_datapath.sv
// mips_multicycle_datapath: 32-bit multicycle MIPS datapath with a unified instruction/data memory port
module mips_multicycle_datapath (
  input  logic        ck,
  input  logic        reset_,
  input  logic        IorD,
  input  logic        IRWrite,
  input  logic        RegDest,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic        ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [2:0]  ALUControl,
  input  logic        Branch,
  input  logic        PCWrite,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] RD,
  output logic [31:0] Adr,
  output logic [31:0] WD,
  output logic        overflow
);
  logic [31:0] pc, instr, data, a, b, alu_out;
  logic [31:0] alu_result, src_a, src_b, sign_imm, pc_next, rd1, rd2, wd3;
  logic [31:0] rf [32];
  logic [4:0]  wa;
  logic        zero, pc_en;
  logic        unused_opcode;
  assign unused_opcode = ^instr[31:26];
  assign sign_imm = {{16{instr[15]}}, instr[15:0]};
  assign src_a = ALUSrcA ? a : pc;
  assign src_b = ALUSrcB == 2'b00 ? b :
                 ALUSrcB == 2'b01 ? 32'd4 :
                 ALUSrcB == 2'b10 ? sign_imm : {sign_imm[29:0], 2'b00};
  // ALU operation select
  always_comb begin
    alu_result = '0;
    case (ALUControl)
      3'b000:  alu_result = src_a & src_b;
      3'b001:  alu_result = src_a | src_b;
      3'b010:  alu_result = src_a + src_b;
      3'b110:  alu_result = src_a - src_b;
      3'b111:  alu_result = {31'b0, $signed(src_a) < $signed(src_b)};
      3'b100:  alu_result = src_a & ~src_b;
      3'b101:  alu_result = src_a | ~src_b;
      default: alu_result = '0;
    endcase
  end
  assign overflow = ALUControl == 3'b010 ? (src_a[31] == src_b[31]) && (alu_result[31] != src_a[31]) :
                    ALUControl == 3'b110 ? (src_a[31] != src_b[31]) && (alu_result[31] != src_a[31]) : 1'b0;
  assign zero = alu_result == 32'd0;
  assign pc_en = PCWrite | (Branch & zero);
  assign pc_next = PCSrc == 2'b01 ? alu_out :
                   PCSrc == 2'b10 ? {pc[31:28], instr[25:0], 2'b00} : alu_result;
  assign rd1 = instr[25:21] == 5'd0 ? 32'd0 : rf[instr[25:21]];
  assign rd2 = instr[20:16] == 5'd0 ? 32'd0 : rf[instr[20:16]];
  assign wa = RegDest ? instr[15:11] : instr[20:16];
  assign wd3 = MemtoReg ? data : alu_out;
  assign Adr = IorD ? alu_out : pc;
  assign WD = b;
  // datapath pipeline registers; PC and IR load only when enabled
  always_ff @(posedge ck) begin
    if (reset_) begin
      pc <= '0;
      instr <= '0;
      data <= '0;
      a <= '0;
      b <= '0;
      alu_out <= '0;
    end else begin
      data <= RD;
      a <= rd1;
      b <= rd2;
      alu_out <= alu_result;
      if (IRWrite) instr <= RD;
      if (pc_en) pc <= pc_next;
    end
  end
  // register file write port; $0 is never written so it always reads zero
  always_ff @(posedge ck) begin
    if (reset_) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (RegWrite && wa != 5'd0) begin
      rf[wa] <= wd3;
    end
  end
endmodule

// File: tb/tb_mips_multicycle_datapath.sv
// tb_mips_multicycle_datapath: scoreboard bench with an architectural-state reference model
module tb_mips_multicycle_datapath;
  logic        ck = 1'b0;
  logic        rst, iord, irwrite, regdest, memtoreg, regwrite, alusrca, branch, pcwrite;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  aluctl;
  logic [31:0] rd, adr, wd;
  logic        ovf;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [64:0] exp_q [$];
  string       nm_q [$];
  logic [31:0] m_pc, m_instr, m_data, m_a, m_b, m_aluout;
  logic [31:0] m_regs [32];

  always #5 ck = ~ck;

  mips_multicycle_datapath dut (
    .ck(ck), .reset_(rst), .IorD(iord), .IRWrite(irwrite), .RegDest(regdest),
    .MemtoReg(memtoreg), .RegWrite(regwrite), .ALUSrcA(alusrca), .ALUSrcB(alusrcb),
    .ALUControl(aluctl), .Branch(branch), .PCWrite(pcwrite), .PCSrc(pcsrc),
    .RD(rd), .Adr(adr), .WD(wd), .overflow(ovf)
  );

  function automatic logic [31:0] m_alu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x + y;
      3'd6: return x - y;
      3'd7: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd4: return x & ~y;
      3'd5: return x | ~y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_ovf(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint s;
    s = (op == 3'd2) ? longint'($signed(x)) + longint'($signed(y)) : longint'($signed(x)) - longint'($signed(y));
    return (op == 3'd2 || op == 3'd6) && (s > 64'sd2147483647 || s < -64'sd2147483648);
  endfunction

  task automatic m_clear();
    m_pc = 0; m_instr = 0; m_data = 0; m_a = 0; m_b = 0; m_aluout = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
  endtask

  task automatic idle();
    {iord, irwrite, regdest, memtoreg, regwrite, alusrca, alusrcb, aluctl, branch, pcwrite, pcsrc} = '0;
    rd = 0;
    rst = 0;
  endtask

  // predict this cycle's outputs, queue them, then advance the model across the edge
  task automatic step(input string nm);
    logic [31:0] sa, sb, si, res, n_a, n_b;
    logic [4:0]  w;
    si = {{16{m_instr[15]}}, m_instr[15:0]};
    sa = alusrca ? m_a : m_pc;
    sb = alusrcb == 2'd0 ? m_b : alusrcb == 2'd1 ? 32'd4 : alusrcb == 2'd2 ? si : si * 4;
    res = m_alu(aluctl, sa, sb);
    exp_q.push_back({iord ? m_aluout : m_pc, m_b, m_ovf(aluctl, sa, sb)});
    nm_q.push_back(nm);
    if (rst) m_clear();
    else begin
      n_a = m_regs[m_instr[25:21]];
      n_b = m_regs[m_instr[20:16]];
      w = regdest ? m_instr[15:11] : m_instr[20:16];
      if (regwrite && w != 0) m_regs[w] = memtoreg ? m_data : m_aluout;
      if (pcwrite || (branch && res == 0))
        m_pc = pcsrc == 2'd1 ? m_aluout : pcsrc == 2'd2 ? {m_pc[31:28], m_instr[25:0], 2'b00} : res;
      m_a = n_a;
      m_b = n_b;
      m_data = rd;
      if (irwrite) m_instr = rd;
      m_aluout = res;
    end
    @(posedge ck);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ins, input string nm);
    idle();
    irwrite = 1; alusrcb = 2'b01; aluctl = 3'b010; pcwrite = 1; rd = ins;
    step(nm);
    idle();
    step({nm, "_decode"});
  endtask

  // monitor: outputs are valid every cycle, compare on the falling edge
  always @(negedge ck) begin
    if (exp_q.size() > 0) begin
      logic [64:0] e;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      n_tests += 3;
      if (adr !== e[64:33]) begin n_fail++; $display("FAIL %s adr: got %h expected %h", n, adr, e[64:33]); end
      if (wd !== e[32:1]) begin n_fail++; $display("FAIL %s wd: got %h expected %h", n, wd, e[32:1]); end
      if (ovf !== e[0]) begin n_fail++; $display("FAIL %s overflow: got %b expected %b", n, ovf, e[0]); end
    end
  end

  initial begin
    idle();
    rst = 1;
    @(posedge ck);
    #1;
    m_clear();
    idle();
    step("reset_out");
    fetch(32'h8C010004, "fetch_lw");
    alusrca = 1; alusrcb = 2'b10; aluctl = 3'b010;
    step("lw_addr");
    idle(); iord = 1; rd = 32'h7FFFFFFF;
    step("lw_mem");
    idle(); memtoreg = 1; regwrite = 1;
    step("lw_wb");
    fetch(32'h20220001, "fetch_addi");
    alusrca = 1; alusrcb = 2'b10; aluctl = 3'b010;
    step("ovf_add");
    aluctl = 3'b000;
    step("ovf_and");
    aluctl = 3'b110; alusrcb = 2'b00;
    step("sub_nonovf");
    fetch(32'hAC010000, "fetch_sw");
    step("sw_wd");
    fetch(32'h10210002, "fetch_beq_eq");
    alusrcb = 2'b11; aluctl = 3'b010;
    step("beq_target");
    idle(); alusrca = 1; aluctl = 3'b110; branch = 1; pcsrc = 2'b01;
    step("beq_taken");
    idle();
    step("beq_after");
    fetch(32'h10200002, "fetch_beq_ne");
    alusrcb = 2'b11; aluctl = 3'b010;
    step("bne_target");
    idle(); alusrca = 1; aluctl = 3'b110; branch = 1; pcsrc = 2'b01;
    step("beq_not_taken");
    idle();
    step("bne_after");
    fetch(32'h08000010, "fetch_j");
    pcsrc = 2'b10; pcwrite = 1;
    step("jump");
    idle();
    step("jump_after");
    fetch(32'h8C000000, "fetch_lw_r0");
    idle(); rd = 32'hFFFFFFFF;
    step("r0_mem");
    idle(); memtoreg = 1; regwrite = 1;
    step("r0_wb");
    idle();
    step("r0_read");
    step("r0_wd");
    for (int i = 0; i < 400; i++) begin
      {iord, irwrite, regdest, memtoreg, regwrite, alusrca, alusrcb, aluctl, branch, pcwrite, pcsrc} = 15'($urandom);
      rd = $urandom;
      rst = ($urandom_range(0, 39) == 0);
      step("random");
    end
    idle();
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge ck);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
